// File: rtl/bram_input_fifo.sv
// ---------------------------------------------------------------------------
// bram_input_fifo
//
// First-word-fall-through FIFO that buffers words from the ACP read path on
// their way to the accelerator datapath. Valid/ready handshakes are used on
// both sides. An occupancy counter tracks full and empty exactly, so all
// LENGTH entries can hold data.
//
// Optional feature macro: ACP_INPUT_FIFO_LEVEL_EN
//   defined   -> the occupancy port 'level' is present and driven from count
//   undefined -> 'level' is not present; count is still kept internally
//
// Parameters
//   DATA_WIDTH          word width in bits
//   LENGTH              depth in words (power of two, >= 2)
//   ALMOST_FULL_MARGIN  almost_full is set when level >= LENGTH - margin
//
// Ports
//   clk          rising-edge clock
//   reset_n      synchronous reset, active-low; has priority over everything
//   flush        synchronous clear of pointers and count; storage is kept
//   s_valid      write side: s_data carries a valid word
//   s_ready      write side: FIFO can take a word (not full)
//   s_data       write data
//   m_valid      read side: m_data carries the head word (not empty)
//   m_ready      read side: consumer takes the head word
//   m_data       head word, read combinationally from storage
//   empty        occupancy == 0
//   full         occupancy == LENGTH
//   almost_full  occupancy >= LENGTH - ALMOST_FULL_MARGIN
//   level        occupancy (only with ACP_INPUT_FIFO_LEVEL_EN)
// ---------------------------------------------------------------------------
module bram_input_fifo #(
  parameter int DATA_WIDTH         = 32,
  parameter int LENGTH             = 16,
  parameter int ALMOST_FULL_MARGIN = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [DATA_WIDTH-1:0]     s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DATA_WIDTH-1:0]     m_data,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_full
`ifdef ACP_INPUT_FIFO_LEVEL_EN
  ,
  output logic [$clog2(LENGTH):0]   level
`endif
);

  localparam int AW = $clog2(LENGTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] COUNT_FULL = CW'(LENGTH);
  localparam logic [CW-1:0] AF_THRESH  = CW'(LENGTH - ALMOST_FULL_MARGIN);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  logic [DATA_WIDTH-1:0] mem [LENGTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;

  logic                  push;
  logic                  pop;

  // Status flags derive only from registered count, so m_valid never
  // follows s_valid within the same cycle.
  always_comb begin
    empty       = (count == '0);
    full        = (count == COUNT_FULL);
    almost_full = (count >= AF_THRESH);
    s_ready     = !full;
    m_valid     = !empty;
    m_data      = mem[rd_ptr];
  end

  assign push = s_valid && s_ready;
  assign pop  = m_valid && m_ready;

`ifdef ACP_INPUT_FIFO_LEVEL_EN
  assign level = count;
`endif

  // Storage: cleared by reset only. Flush leaves the contents in place and
  // also blocks the write that would otherwise happen in that cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < LENGTH; i++) begin
        mem[i] <= '0;
      end
    end else if (!flush && push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // Pointers wrap naturally at LENGTH because LENGTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_input_fifo.sv
module tb_bram_input_fifo;

  localparam int DW  = 32;
  localparam int LEN = 16;
  localparam int AFM = 4;

  logic          clk;
  logic          reset_n;
  logic          flush;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          empty;
  logic          full;
  logic          almost_full;
`ifdef ACP_INPUT_FIFO_LEVEL_EN
  logic [$clog2(LEN):0] level;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  logic [DW-1:0] q [$];

  bram_input_fifo #(
    .DATA_WIDTH        (DW),
    .LENGTH            (LEN),
    .ALMOST_FULL_MARGIN(AFM)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .empty      (empty),
    .full       (full),
    .almost_full(almost_full)
`ifdef ACP_INPUT_FIFO_LEVEL_EN
    ,
    .level      (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive inputs just after the rising edge, compare outputs to
  // the queue model at the falling edge, then advance the model at the edge.
  task automatic step(input logic sv, input logic [DW-1:0] sd,
                      input logic mr, input logic fl);
    bit exp_full, exp_empty, exp_af, do_push, do_pop;
    logic [DW-1:0] head;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush   = fl;
    @(negedge clk);
    exp_full  = (q.size() == LEN);
    exp_empty = (q.size() == 0);
    exp_af    = (q.size() >= LEN - AFM);
    chk("s_ready",     32'(s_ready),     32'(!exp_full));
    chk("m_valid",     32'(m_valid),     32'(!exp_empty));
    chk("empty",       32'(empty),       32'(exp_empty));
    chk("full",        32'(full),        32'(exp_full));
    chk("almost_full", 32'(almost_full), 32'(exp_af));
`ifdef ACP_INPUT_FIFO_LEVEL_EN
    chk("level",       32'(level),       32'(q.size()));
`endif
    if (!exp_empty) chk("m_data", m_data, q[0]);
    do_push = sv && !exp_full;
    do_pop  = mr && !exp_empty;
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
    end else begin
      if (do_pop)  head = q.pop_front();
      if (do_push) q.push_back(sd);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * LEN && q.size() > 0; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two cycles with a word offered; nothing must be stored.
    reset_n = 1'b0;
    flush   = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hDEADBEEF;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_empty",   32'(empty),   32'd1);
    chk("rst_full",    32'(full),    32'd0);
    chk("rst_af",      32'(almost_full), 32'd0);
    chk("rst_m_data",  m_data,       32'd0);
`ifdef ACP_INPUT_FIFO_LEVEL_EN
    chk("rst_level",   32'(level),   32'd0);
`endif
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    s_valid = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0);
    chk("post_rst_m_data", m_data, 32'd0);

    // Fill to full, offer a 17th word, then drain in order.
    for (int i = 1; i <= LEN; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
    step(1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h11, 1'b0, 1'b0);
    for (int i = 0; i < LEN; i++) step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);

    // Continuous streaming, pointers wrap several times.
    for (int i = 0; i < 120; i++) step(1'b1, 32'h1000 + DW'(i), 1'b1, 1'b0);
    drain();

    // Full with simultaneous offer and take: pop only, then the push lands.
    for (int i = 0; i < LEN; i++) step(1'b1, 32'h200 + DW'(i), 1'b0, 1'b0);
    step(1'b1, 32'hAA, 1'b1, 1'b0);
    step(1'b1, 32'hAA, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    drain();

    // Flush at level 7 overrides a concurrent push and pop.
    for (int i = 0; i < 7; i++) step(1'b1, 32'h300 + DW'(i), 1'b0, 1'b0);
    step(1'b1, 32'h3FF, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 32'h400, 1'b0, 1'b0);
    drain();

    // Random traffic against the queue model.
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
